// File: rtl/prism_in_cond.sv
// Input conditioner for PRISM controller inputs: synchronizer, per-bit glitch
// filter with a shared prescaled sample tick, edge pulses and a sticky event/IRQ block.
module prism_in_cond #(
    parameter int WIDTH  = 8,
    parameter int FILT_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [15:0]      wr_data,
    output logic [15:0]      rd_data,
    output logic [WIDTH-1:0] cond_out,
    output logic [WIDTH-1:0] rise_p,
    output logic [WIDTH-1:0] fall_p,
    output logic             irq
);

    // Field layout reserves 8 bits per per-pin field, so WIDTH is limited to 1..8.
    localparam logic [3:0] CNT_MAX = 4'(FILT_N - 1);

    logic [WIDTH-1:0]      sync1_r;
    logic [WIDTH-1:0]      sync_r;
    logic [WIDTH-1:0]      cond_r;
    logic [WIDTH-1:0]      cond_prev_r;
    logic [WIDTH-1:0]      filt_en_r;
    logic [WIDTH-1:0]      rise_en_r;
    logic [WIDTH-1:0]      fall_en_r;
    logic [WIDTH-1:0]      events_r;
    logic [7:0]            prescale_r;
    logic [7:0]            pcnt_r;
    logic [WIDTH-1:0][3:0] fcnt_r;

    logic                  tick_s;
    logic                  ctrl_wr_s;
    logic                  edge_wr_s;
    logic                  ev_wr_s;
    logic [WIDTH-1:0]      cond_nxt_s;
    logic [WIDTH-1:0][3:0] fcnt_nxt_s;
    logic [WIDTH-1:0]      ev_set_s;
    logic [WIDTH-1:0]      ev_clr_s;

    function automatic logic [7:0] pad8(input logic [WIDTH-1:0] v);
        logic [7:0] r;
        r           = 8'h00;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign ctrl_wr_s = wr_en && (addr == 2'd0);
    assign edge_wr_s = wr_en && (addr == 2'd1);
    assign ev_wr_s   = wr_en && (addr == 2'd2);
    assign tick_s    = (pcnt_r == prescale_r);

    assign rise_p = cond_r & ~cond_prev_r;
    assign fall_p = ~cond_r & cond_prev_r;
    assign ev_set_s = (rise_p & rise_en_r) | (fall_p & fall_en_r);
    assign ev_clr_s = ev_wr_s ? wr_data[WIDTH-1:0] : {WIDTH{1'b0}};
    assign cond_out = cond_r;
    assign irq      = |events_r;

    // Two-flop synchronizer for the raw pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {WIDTH{1'b0}};
            sync_r  <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= pin_in;
            sync_r  <= sync1_r;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_en_r  <= {WIDTH{1'b0}};
            prescale_r <= 8'h00;
            rise_en_r  <= {WIDTH{1'b0}};
            fall_en_r  <= {WIDTH{1'b0}};
        end else begin
            if (ctrl_wr_s) begin
                filt_en_r  <= wr_data[WIDTH-1:0];
                prescale_r <= wr_data[15:8];
            end
            if (edge_wr_s) begin
                rise_en_r <= wr_data[WIDTH-1:0];
                fall_en_r <= wr_data[8 +: WIDTH];
            end
        end
    end

    // Sample-tick prescaler; a CTRL write restarts the tick phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= 8'h00;
        end else if (ctrl_wr_s || tick_s) begin
            pcnt_r <= 8'h00;
        end else begin
            pcnt_r <= pcnt_r + 8'd1;
        end
    end

    // Per-bit filter next state: bypass, hold between ticks, or count disagreement.
    always_comb begin
        cond_nxt_s = cond_r;
        fcnt_nxt_s = fcnt_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (!filt_en_r[i]) begin
                cond_nxt_s[i] = sync_r[i];
                fcnt_nxt_s[i] = 4'd0;
            end else if (!tick_s) begin
                cond_nxt_s[i] = cond_r[i];
                fcnt_nxt_s[i] = fcnt_r[i];
            end else if (sync_r[i] == cond_r[i]) begin
                fcnt_nxt_s[i] = 4'd0;
            end else if (fcnt_r[i] < CNT_MAX) begin
                fcnt_nxt_s[i] = fcnt_r[i] + 4'd1;
            end else begin
                cond_nxt_s[i] = sync_r[i];
                fcnt_nxt_s[i] = 4'd0;
            end
        end
    end

    // Filter state, edge history and sticky events (set beats a same-cycle clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_r      <= {WIDTH{1'b0}};
            cond_prev_r <= {WIDTH{1'b0}};
            fcnt_r      <= '0;
            events_r    <= {WIDTH{1'b0}};
        end else begin
            cond_r      <= cond_nxt_s;
            cond_prev_r <= cond_r;
            fcnt_r      <= fcnt_nxt_s;
            events_r    <= (events_r & ~ev_clr_s) | ev_set_s;
        end
    end

    // Combinational register read mux.
    always_comb begin
        rd_data = 16'h0000;
        case (addr)
            2'd0:    rd_data = {prescale_r, pad8(filt_en_r)};
            2'd1:    rd_data = {pad8(fall_en_r), pad8(rise_en_r)};
            2'd2:    rd_data = {8'h00, pad8(events_r)};
            2'd3:    rd_data = {pad8(sync_r), pad8(cond_r)};
            default: rd_data = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_prism_in_cond.sv
// Directed bench for prism_in_cond: expectations are queued with a due cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_prism_in_cond;

    logic        clk;
    logic        rst;
    logic [7:0]  pin_in;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [7:0]  cond_out;
    logic [7:0]  rise_p;
    logic [7:0]  fall_p;
    logic        irq;

    prism_in_cond #(.WIDTH(8), .FILT_N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pin_in),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .cond_out(cond_out),
        .rise_p  (rise_p),
        .fall_p  (fall_p),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        int          sel;
        logic [15:0] exp;
    } sb_t;

    localparam int S_COND = 0;
    localparam int S_RISE = 1;
    localparam int S_FALL = 2;
    localparam int S_IRQ  = 3;
    localparam int S_RD   = 4;

    sb_t sb[$];
    int  cyc_n  = 0;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_COND:  return {8'h00, cond_out};
            S_RISE:  return {8'h00, rise_p};
            S_FALL:  return {8'h00, fall_p};
            S_IRQ:   return {15'h0000, irq};
            S_RD:    return rd_data;
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic expect_at(input int dly, input string tag, input int sel, input logic [15:0] v);
        sb_t e;
        e.due = cyc_n + dly;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        int          i;
        logic [15:0] obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc_n) begin
                obs = observe(sb[i].sel);
                checks++;
                assert (obs === sb[i].exp) else begin
                    errors++;
                    $error("FAIL %s observed %h expected %h", sb[i].tag, obs, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        drain();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        cyc();
        wr_en   = 1'b0;
        wr_data = 16'h0000;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] v);
        addr = a;
        #1;
        expect_at(0, tag, S_RD, v);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pin_in = 8'h00; wr_en = 1'b0; addr = 2'd0; wr_data = 16'h0000;
        #1 rst = 1'b1;
        #1;
        expect_at(0, "rst_cond", S_COND, 16'h0000);
        expect_at(0, "rst_irq",  S_IRQ,  16'h0000);
        drain();
        rd_chk("rst_rd0", 2'd0, 16'h0000);
        rd_chk("rst_rd1", 2'd1, 16'h0000);
        rd_chk("rst_rd2", 2'd2, 16'h0000);
        rd_chk("rst_rd3", 2'd3, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Unfiltered path: three-cycle latency, one-cycle rise then fall pulse.
        pin_in = 8'h01;
        expect_at(2, "t1_cond_lat",  S_COND, 16'h0000);
        expect_at(3, "t1_cond",      S_COND, 16'h0001);
        expect_at(3, "t1_rise",      S_RISE, 16'h0001);
        expect_at(4, "t1_rise_end",  S_RISE, 16'h0000);
        expect_at(4, "t1_cond_hold", S_COND, 16'h0001);
        cyc(); cyc();
        rd_chk("t1_status", 2'd3, 16'h0100);
        cyc(); cyc();
        pin_in = 8'h00;
        expect_at(2, "t1_fall_lat", S_COND, 16'h0001);
        expect_at(3, "t1_fall",     S_FALL, 16'h0001);
        expect_at(4, "t1_fall_end", S_FALL, 16'h0000);
        expect_at(4, "t1_irq",      S_IRQ,  16'h0000);
        repeat (4) cyc();

        // Filter with tick every cycle: a 2-cycle glitch is rejected.
        wr(2'd0, 16'h0001);
        pin_in = 8'h01;
        expect_at(4, "t2_glitch_a", S_COND, 16'h0000);
        expect_at(6, "t2_glitch_b", S_COND, 16'h0000);
        cyc(); cyc();
        pin_in = 8'h00;
        repeat (4) cyc();
        pin_in = 8'h01;
        expect_at(4, "t2_pre",  S_COND, 16'h0000);
        expect_at(5, "t2_cond", S_COND, 16'h0001);
        expect_at(5, "t2_rise", S_RISE, 16'h0001);
        repeat (5) cyc();

        // Prescale 3: ticks every 4 cycles, change lands 12 cycles after sync.
        wr(2'd0, 16'h0301);
        rd_chk("t3_ctrl", 2'd0, 16'h0301);
        cyc(); cyc();
        pin_in = 8'h00;
        expect_at(9,  "t3_mid",  S_COND, 16'h0001);
        expect_at(13, "t3_pre",  S_COND, 16'h0001);
        expect_at(14, "t3_cond", S_COND, 16'h0000);
        expect_at(14, "t3_fall", S_FALL, 16'h0001);
        repeat (14) cyc();
        wr(2'd0, 16'h0000);

        // Events: only falls qualified, irq after the fall, W1C clears.
        wr(2'd1, 16'h0100);
        rd_chk("t4_edge", 2'd1, 16'h0100);
        pin_in = 8'h01;
        expect_at(3, "t4_rise",      S_RISE, 16'h0001);
        expect_at(4, "t4_irq_rise",  S_IRQ,  16'h0000);
        repeat (4) cyc();
        rd_chk("t4_ev_rise", 2'd2, 16'h0000);
        pin_in = 8'h00;
        expect_at(3, "t4_fall",     S_FALL, 16'h0001);
        expect_at(3, "t4_irq_lat",  S_IRQ,  16'h0000);
        expect_at(4, "t4_irq_fall", S_IRQ,  16'h0001);
        repeat (4) cyc();
        rd_chk("t4_ev_fall", 2'd2, 16'h0001);
        expect_at(1, "t4_w1c_other", S_IRQ, 16'h0001);
        wr(2'd2, 16'h00FE);
        expect_at(1, "t4_irq_clr", S_IRQ, 16'h0000);
        wr(2'd2, 16'h0001);
        rd_chk("t4_ev_clr", 2'd2, 16'h0000);

        // Set-vs-clear race: W1C lands on the same edge the fall event sets.
        pin_in = 8'h01;
        repeat (4) cyc();
        pin_in = 8'h00;
        expect_at(3, "t5_fall", S_FALL, 16'h0001);
        repeat (3) cyc();
        expect_at(1, "t5_race_irq", S_IRQ, 16'h0001);
        wr(2'd2, 16'h0001);
        rd_chk("t5_race_ev", 2'd2, 16'h0001);
        expect_at(1, "t5_clr_irq", S_IRQ, 16'h0000);
        wr(2'd2, 16'h0001);

        // Async reset mid-count and with a pending event.
        wr(2'd1, 16'h0101);
        pin_in = 8'h01;
        expect_at(4, "t6_irq_set", S_IRQ, 16'h0001);
        repeat (4) cyc();
        wr(2'd0, 16'h0301);
        pin_in = 8'h00;
        expect_at(6, "t6_mid", S_COND, 16'h0001);
        repeat (6) cyc();
        #3 rst = 1'b1;
        #1;
        expect_at(0, "t6_rst_cond", S_COND, 16'h0000);
        expect_at(0, "t6_rst_rise", S_RISE, 16'h0000);
        expect_at(0, "t6_rst_fall", S_FALL, 16'h0000);
        expect_at(0, "t6_rst_irq",  S_IRQ,  16'h0000);
        drain();
        rd_chk("t6_rst_ctrl", 2'd0, 16'h0000);
        rd_chk("t6_rst_edge", 2'd1, 16'h0000);
        rd_chk("t6_rst_ev",   2'd2, 16'h0000);
        rd_chk("t6_rst_stat", 2'd3, 16'h0000);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            expect_at(k, "t6_post_fall", S_FALL, 16'h0000);
            expect_at(k, "t6_post_cond", S_COND, 16'h0000);
        end
        expect_at(5, "t6_post_irq", S_IRQ, 16'h0000);
        repeat (5) cyc();
        pin_in = 8'h01;
        expect_at(2, "t6_new_lat",  S_RISE, 16'h0000);
        expect_at(3, "t6_new_rise", S_RISE, 16'h0001);
        expect_at(4, "t6_new_irq",  S_IRQ,  16'h0000);
        repeat (4) cyc();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
